meas_freq_gen: RTL and testbench
================================

# meas_freq_gen

Parametrised equal-precision frequency meter, the next generation of the fixed 6 MHz / 28-bit meter. It opens and closes its measurement window on synchronised rising edges of the input square wave, so every window contains a whole number of input periods. It adds single-shot and continuous modes, a result-valid strobe, a no-signal timeout and configurable widths. It sits between the raw square input pin and the frequency/display arithmetic, which computes f = F_clk · cnt_squ / cnt_clk.

## Interface
- CNT_W, 28 — width of all result counters.
- GATE_CYCLES, 6_000_000 — minimum window length in clk_6M cycles. Must be ≥ 1.
- TIMEOUT_CYCLES, 12_000_000 — maximum clk_6M cycles allowed between consecutive rising edges while armed or measuring. Must be ≥ 2.
- SYNC_STAGES, 2 — synchroniser depth on `square`. Must be ≥ 2.
- Constraint: GATE_CYCLES + TIMEOUT_CYCLES < 2^CNT_W.
- clk_6M  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- square  in  1  asynchronous input under measurement.
- start  in  1  single-shot trigger, sampled only in IDLE.
- continuous  in  1  1 = re-arm automatically; 0 = wait for `start`.
- cnt_clk  out  CNT_W  clk_6M cycles in the last completed window.
- cnt_squ  out  CNT_W  complete square periods in the last completed window.
- cnt_high  out  CNT_W  clk_6M cycles with square high in the window (MEAS_DUTY_EN only).
- valid  out  1  one-cycle pulse; results updated this cycle.
- timeout  out  1  sticky no-signal flag.
- busy  out  1  high in ARM and MEAS.

## Operation
- Synchroniser: SYNC_STAGES flops produce `s`, followed by one delay flop `s_d`.
  - `rise = s & ~s_d`.
  - Latency from a pin edge to `rise` is SYNC_STAGES+1 cycles.
- FSM states: IDLE, ARM, MEAS. Reset state is IDLE.
- IDLE
  - busy=0.
  - Go to ARM when continuous=1, or when start=1.
  - `start` is ignored in every other state.
- ARM
  - Wait for `rise`.
  - On `rise`, go to MEAS and set acc_clk←1, acc_squ←0, gate_tmr←1, acc_high←1.
- MEAS
  - Every cycle, acc_clk increments.
  - gate_tmr increments and saturates at GATE_CYCLES.
  - acc_high increments when s=1.
  - A `rise` with gate_tmr<GATE_CYCLES increments acc_squ.
- Close: on a `rise` with gate_tmr==GATE_CYCLES, the window closes.
  - Registers update: cnt_clk←acc_clk, cnt_squ←acc_squ+1, cnt_high←acc_high.
  - valid←1 and timeout←0.
  - If continuous=1, the closing edge opens the next window in the same cycle (accumulators reload as in ARM) and the FSM stays in MEAS, giving zero dead time.
  - Otherwise the FSM goes to IDLE.
- Timeout
  - idle_cnt clears on every `rise` and counts in ARM and MEAS.
  - When idle_cnt reaches TIMEOUT_CYCLES-1: timeout←1, FSM→IDLE, no valid pulse, and cnt_* keep their previous values.
  - In continuous mode the FSM re-arms on the following cycle.
- Deasserting `continuous` during MEAS: the current window completes, then the FSM goes to IDLE.
- Arithmetic: all accumulators saturate at 2^CNT_W-1 and never wrap. Saturation is unreachable under the parameter constraint.

## Timing
- Reset (rst_n=0 at a clock edge) clears all outputs to 0 (cnt_clk, cnt_squ, cnt_high, valid, timeout, busy) and forces IDLE.
- Reset mid-window discards the partial result.
- valid and the new cnt_* values appear one cycle after the closing `rise` cycle, in the same cycle.
- Window length in clock cycles is exactly the sum of the complete square periods it contains.
- Minimum window is GATE_CYCLES cycles; maximum is GATE_CYCLES + one input period.
- busy rises the cycle after leaving IDLE.
- Simultaneous close and timeout cannot occur, because a `rise` clears idle_cnt.

## Configuration
- MEAS_DUTY_EN
  - Defined: acc_high and the `cnt_high` port exist, reporting high-time cycles for duty computation.
  - Undefined: the port is absent and the counter logic is removed.
  - All other behaviour is identical in both cases.

## Test plan
- GATE_CYCLES=60, continuous=1, square period 6 clk (50% duty) → valid every 60 cycles with cnt_clk=60, cnt_squ=10, cnt_high=30. Back-to-back windows with no lost edge.
- GATE_CYCLES=60, square period 7 → cnt_clk=63, cnt_squ=9 each window.
- continuous=0, one `start` pulse, period 6 → exactly one valid pulse, then busy=0. A `start` pulsed while busy produces no second window.
- TIMEOUT_CYCLES=100, square held low, continuous=1 → timeout=1 after 100 cycles in ARM with no valid pulse and prior cnt_* held. Restoring the square gives the next valid, and timeout returns to 0.
- rst_n low for one cycle mid-MEAS → all outputs 0 and IDLE. The next window reports full correct counts (60/10).
- Square stops mid-window (TIMEOUT_CYCLES=100) → timeout set, no valid pulse, and cnt_* unchanged.

Source files
------------

// File: rtl/meas_freq_gen.sv
// meas_freq_gen: equal-precision frequency meter.
// Each measurement window opens and closes on a synchronised rising edge of
// `square`, so a window always holds a whole number of input periods. Supports
// single-shot and continuous modes, a result-valid strobe and a no-signal timeout.
// Optional feature: define MEAS_DUTY_EN to add the high-time counter and the
// cnt_high port for duty-cycle computation.
module meas_freq_gen #(
    parameter int CNT_W          = 28,
    parameter int GATE_CYCLES    = 6_000_000,
    parameter int TIMEOUT_CYCLES = 12_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk_6M,
    input  logic             rst_n,
    input  logic             square,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] cnt_clk,
    output logic [CNT_W-1:0] cnt_squ,
`ifdef MEAS_DUTY_EN
    output logic [CNT_W-1:0] cnt_high,
`endif
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] GATE_MAX = CNT_W'(GATE_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic [CNT_W-1:0]       acc_clk;
    logic [CNT_W-1:0]       acc_squ;
    logic [CNT_W-1:0]       gate_tmr;
    logic [CNT_W-1:0]       idle_cnt;
`ifdef MEAS_DUTY_EN
    logic [CNT_W-1:0]       acc_high;
`endif

    // Saturating increment: the counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    // Synchroniser chain plus one delay flop for rising-edge detection.
    always_ff @(posedge clk_6M) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], square};
            s_d    <= s;
        end
    end

    // Measurement FSM: arms on a rise, closes on the first rise after the gate
    // time has elapsed, and gives up if edges stop arriving.
    always_ff @(posedge clk_6M) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            cnt_clk  <= '0;
            cnt_squ  <= '0;
            acc_clk  <= '0;
            acc_squ  <= '0;
            gate_tmr <= '0;
            idle_cnt <= '0;
`ifdef MEAS_DUTY_EN
            cnt_high <= '0;
            acc_high <= '0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (continuous || start) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end

                ARM: begin
                    if (rise) begin
                        // Opening edge: this cycle is the first of the window.
                        state    <= MEAS;
                        acc_clk  <= ONE;
                        acc_squ  <= '0;
                        gate_tmr <= ONE;
                        idle_cnt <= '0;
`ifdef MEAS_DUTY_EN
                        acc_high <= ONE;
`endif
                    end else if (idle_cnt == TO_LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        idle_cnt <= sat_inc(idle_cnt);
                    end
                end

                MEAS: begin
                    acc_clk <= sat_inc(acc_clk);
                    if (gate_tmr < GATE_MAX)
                        gate_tmr <= gate_tmr + ONE;
`ifdef MEAS_DUTY_EN
                    if (s)
                        acc_high <= sat_inc(acc_high);
`endif
                    if (rise) begin
                        idle_cnt <= '0;
                        if (gate_tmr == GATE_MAX) begin
                            // Closing edge ends the last complete period.
                            cnt_clk <= acc_clk;
                            cnt_squ <= sat_inc(acc_squ);
`ifdef MEAS_DUTY_EN
                            cnt_high <= acc_high;
`endif
                            valid   <= 1'b1;
                            timeout <= 1'b0;
                            if (continuous) begin
                                // Same edge opens the next window: no dead time.
                                acc_clk  <= ONE;
                                acc_squ  <= '0;
                                gate_tmr <= ONE;
`ifdef MEAS_DUTY_EN
                                acc_high <= ONE;
`endif
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            acc_squ <= sat_inc(acc_squ);
                        end
                    end else if (idle_cnt == TO_LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        idle_cnt <= sat_inc(idle_cnt);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_meas_freq_gen.sv
// tb_meas_freq_gen: directed and randomized check of meas_freq_gen against a
// reference model that derives windows from the driven pin-edge times.
module tb_meas_freq_gen;

    localparam int CNT_W = 16;
    localparam int GATE  = 60;
    localparam int TOUT  = 100;

    logic             clk;
    logic             rst_n;
    logic             square;
    logic             start;
    logic             continuous;
    logic [CNT_W-1:0] cnt_clk;
    logic [CNT_W-1:0] cnt_squ;
`ifdef MEAS_DUTY_EN
    logic [CNT_W-1:0] cnt_high;
`endif
    logic             valid;
    logic             timeout;
    logic             busy;

    int total = 0;
    int bad   = 0;

    // stimulus: period lengths and high times, one entry per driven rising edge
    int pq[$];
    int hq[$];
    // expected and observed windows
    int ec[$], es[$], eh[$];
    int oc[$], os[$], oh[$];
    int lc, ls, lh;

    meas_freq_gen #(
        .CNT_W(CNT_W), .GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TOUT), .SYNC_STAGES(2)
    ) dut (
        .clk_6M(clk),
        .rst_n(rst_n),
        .square(square),
        .start(start),
        .continuous(continuous),
        .cnt_clk(cnt_clk),
        .cnt_squ(cnt_squ),
`ifdef MEAS_DUTY_EN
        .cnt_high(cnt_high),
`endif
        .valid(valid),
        .timeout(timeout),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
        end
    endtask

    // Record every result strobe; timeout must be clear alongside it.
    always @(negedge clk) begin
        if (rst_n && valid === 1'b1) begin
            oc.push_back(int'(cnt_clk));
            os.push_back(int'(cnt_squ));
`ifdef MEAS_DUTY_EN
            oh.push_back(int'(cnt_high));
`else
            oh.push_back(0);
`endif
            chk("timeout_clear_on_valid", timeout, 0);
        end
    end

    // Reference: windows start at a rise, end at the first rise >= GATE later.
    task automatic model(input bit single);
        int t[$];
        int a, b, acc;
        ec.delete(); es.delete(); eh.delete();
        acc = 0;
        foreach (pq[i]) begin
            t.push_back(acc);
            acc += pq[i];
        end
        a = 0;
        while (a < t.size()) begin
            b = a + 1;
            while (b < t.size() && t[b] - t[a] < GATE) b++;
            if (b >= t.size()) break;
            ec.push_back(t[b] - t[a]);
            es.push_back(b - a);
            acc = 0;
            for (int k = a; k < b; k++) acc += hq[k];
            eh.push_back(acc);
            if (single) break;
            a = b;
        end
    endtask

    task automatic drive(input int pulse_at);
        foreach (pq[i]) begin
            square = 1'b1;
            if (i == pulse_at) start = 1'b1;
            repeat (hq[i]) @(negedge clk);
            start  = 1'b0;
            square = 1'b0;
            repeat (pq[i] - hq[i]) @(negedge clk);
        end
    endtask

    task automatic fill(input int n, input int p, input int h);
        pq.delete(); hq.delete();
        repeat (n) begin
            pq.push_back(p);
            hq.push_back(h);
        end
    endtask

    task automatic run_phase(input bit single, input int pulse_at, input string tag);
        oc.delete(); os.delete(); oh.delete();
        model(single);
        if (single) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else begin
            continuous = 1'b1;
        end
        repeat (2) @(negedge clk);
        drive(pulse_at);
        repeat (130) @(negedge clk);
        continuous = 1'b0;
        repeat (110) @(negedge clk);
        chk({tag, "_nwin"}, oc.size(), ec.size());
        for (int i = 0; i < oc.size() && i < ec.size(); i++) begin
            chk({tag, "_clk"}, oc[i], ec[i]);
            chk({tag, "_squ"}, os[i], es[i]);
`ifdef MEAS_DUTY_EN
            chk({tag, "_high"}, oh[i], eh[i]);
`endif
        end
        if (ec.size() > 0) begin
            lc = ec[ec.size()-1];
            ls = es[es.size()-1];
            lh = eh[eh.size()-1];
        end
        chk({tag, "_held_clk"}, cnt_clk, lc);
        chk({tag, "_held_squ"}, cnt_squ, ls);
`ifdef MEAS_DUTY_EN
        chk({tag, "_held_high"}, cnt_high, lh);
`endif
        chk({tag, "_timeout"}, timeout, single ? 0 : 1);
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p;
        rst_n = 1'b0; square = 1'b0; start = 1'b0; continuous = 1'b1;
        lc = 0; ls = 0; lh = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt_clk", cnt_clk, 0);
        chk("rst_cnt_squ", cnt_squ, 0);
`ifdef MEAS_DUTY_EN
        chk("rst_cnt_high", cnt_high, 0);
`endif

        // no signal: timeout after exactly TOUT cycles in ARM
        rst_n = 1'b1;
        @(negedge clk);
        chk("busy_rise", busy, 1);
        repeat (TOUT - 1) @(negedge clk);
        chk("timeout_early", timeout, 0);
        @(negedge clk);
        chk("timeout_set", timeout, 1);
        chk("timeout_no_valid", oc.size(), 0);
        chk("timeout_held_clk", cnt_clk, 0);
        continuous = 1'b0;
        repeat (110) @(negedge clk);
        chk("idle_busy", busy, 0);

        // directed periods
        fill(30, 6, 3);
        run_phase(0, -1, "p6");
        if (oc.size() > 0) begin
            chk("p6_first_clk", oc[0], 60);
            chk("p6_first_squ", os[0], 10);
`ifdef MEAS_DUTY_EN
            chk("p6_first_high", oh[0], 30);
`endif
        end
        fill(30, 7, 3);
        run_phase(0, -1, "p7");
        if (oc.size() > 0) begin
            chk("p7_first_clk", oc[0], 63);
            chk("p7_first_squ", os[0], 9);
        end

        // random period sequences
        for (int r = 0; r < 3; r++) begin
            pq.delete(); hq.delete();
            n = $urandom_range(40, 15);
            repeat (n) begin
                p = $urandom_range(20, 2);
                pq.push_back(p);
                hq.push_back($urandom_range(p - 1, 1));
            end
            run_phase(0, -1, "rand");
        end

        // single shot with a second start pulse while busy
        fill(25, 6, 3);
        run_phase(1, 5, "single");
        if (oc.size() > 0) begin
            chk("single_clk", oc[0], 60);
            chk("single_squ", os[0], 10);
        end

        // reset in the middle of a window
        oc.delete(); os.delete(); oh.delete();
        continuous = 1'b1;
        repeat (2) @(negedge clk);
        fill(5, 6, 3);
        drive(-1);
        chk("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", valid, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt_clk", cnt_clk, 0);
        chk("midrst_cnt_squ", cnt_squ, 0);
        chk("midrst_no_valid", oc.size(), 0);
        rst_n = 1'b1;
        lc = 0; ls = 0; lh = 0;
        repeat (2) @(negedge clk);
        fill(25, 6, 3);
        run_phase(0, -1, "after_rst");
        if (oc.size() > 0) begin
            chk("after_rst_clk", oc[0], 60);
            chk("after_rst_squ", os[0], 10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
